// File: rtl/switch_alloc_main_pkg.sv
// switch_alloc_main_pkg: shared widths, port indices and arbitration helpers
//   N        number of router ports
//   DW       flit data width
//   PW       width of a port index
//   port_e   port index constants (local/N/E/S/W)
package switch_alloc_main_pkg;
   localparam int N = 5;
   localparam int DW = 32;
   localparam int PW = 3;
   typedef enum logic [PW-1:0] {P0 = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3, P4 = 3'd4} port_e;
   // keeps only the lowest set bit; multi-hot requests collapse to it
   function automatic logic [N-1:0] low_bit(input logic [N-1:0] r);
      logic [N-1:0] g;
      g = '0;
      for (int k = N - 1; k >= 0; k--)
         if (r[k]) begin
            g = '0;
            g[k] = 1'b1;
         end
      return g;
   endfunction
   // first set bit of r in the order p, p+1, ... wrapping mod N;
   // walking the order backwards lets the earliest hit overwrite later ones
   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
      logic [N-1:0] g;
      logic [PW-1:0] idx;
      g = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = PW'((int'(p) + k) % N);
         if (r[idx]) begin
            g = '0;
            g[idx] = 1'b1;
         end
      end
      return g;
   endfunction
   function automatic logic [PW-1:0] oh_index(input logic [N-1:0] g);
      logic [PW-1:0] i;
      i = '0;
      for (int k = 0; k < N; k++)
         if (g[k]) i = PW'(k);
      return i;
   endfunction
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
      return (i == PW'(N - 1)) ? '0 : i + PW'(1);
   endfunction
endpackage

// File: rtl/switch_alloc_main_if.sv
// switch_alloc_main_if: input-port/allocator handshake bundle
//   req_from_p[i]   one-hot output-port request of input port i (0 = none)
//   tail_from_p[i]  requested flit of input i is a tail
//   credit_avail[j] output j has a downstream credit
//   grant_to_p[i]   input i granted this cycle (combinational)
//   sel_for_op[j]   registered one-hot input select for output j
//   master: input-port side, slave: allocator side
interface switch_alloc_main_if;
   import switch_alloc_main_pkg::*;
   logic [N-1:0][N-1:0] req_from_p;
   logic [N-1:0] tail_from_p;
   logic [N-1:0] credit_avail;
   logic [N-1:0] grant_to_p;
   logic [N-1:0][N-1:0] sel_for_op;
   modport master (output req_from_p, tail_from_p, credit_avail, input grant_to_p, sel_for_op);
   modport slave (input req_from_p, tail_from_p, credit_avail, output grant_to_p, sel_for_op);
endinterface

// File: rtl/switch_alloc_main_rr_arbiter_lock.sv
// rr_arbiter_lock: per-output round-robin arbiter with wormhole lock
//   clk, rstn  clock, async active-low reset
//   req        per-input request for this output
//   tail       per-input tail flag of the requested flit
//   credit     this output has a downstream credit
//   gnt        one-hot grant (combinational, zero while in reset)
module rr_arbiter_lock
   import switch_alloc_main_pkg::*;
(
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] req,
   input  logic [N-1:0] tail,
   input  logic         credit,
   output logic [N-1:0] gnt
);
   logic [PW-1:0] ptr;
   logic [PW-1:0] lock_idx;
   logic [PW-1:0] gidx;
   logic lock_v;
   logic [N-1:0] lock_mask;
   logic [N-1:0] elig;
   // a held lock masks everyone but the owner; the RR search then finds it or nothing
   always_comb begin
      lock_mask = '0;
      lock_mask[lock_idx] = 1'b1;
      elig = lock_v ? (req & lock_mask) : req;
      gnt = (credit && rstn) ? rr_pick(elig, ptr) : '0;
      gidx = oh_index(gnt);
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         ptr <= '0;
         lock_v <= 1'b0;
         lock_idx <= '0;
      end else if (|gnt) begin
         ptr <= next_ptr(gidx);
         lock_v <= !tail[gidx];
         lock_idx <= gidx;
      end
endmodule

// File: rtl/switch_alloc_main.sv
// switch_alloc_main: output-side switch allocator for the 5-port router
//   clk, rstn  clock, async active-low reset
//   bus        switch_alloc_main_if.slave: requests/tails/credits in,
//              combinational grants and registered crossbar selects out
module switch_alloc_main
   import switch_alloc_main_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   switch_alloc_main_if.slave bus
);
   logic [N-1:0] req_op [N];
   logic [N-1:0] gnt_op [N];
   // transpose per-input one-hot requests into per-output request vectors
   always_comb begin
      logic [N-1:0] low;
      low = '0;
      for (int j = 0; j < N; j++) req_op[j] = '0;
      for (int i = 0; i < N; i++) begin
         low = low_bit(bus.req_from_p[i]);
         for (int j = 0; j < N; j++) req_op[j][i] = low[j];
      end
   end
   for (genvar j = 0; j < N; j++) begin : g_arb
      rr_arbiter_lock u_arb (
         .clk    (clk),
         .rstn   (rstn),
         .req    (req_op[j]),
         .tail   (bus.tail_from_p),
         .credit (bus.credit_avail[j]),
         .gnt    (gnt_op[j])
      );
   end
   always_comb begin
      bus.grant_to_p = '0;
      for (int j = 0; j < N; j++) bus.grant_to_p = bus.grant_to_p | gnt_op[j];
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) bus.sel_for_op <= '0;
      else for (int j = 0; j < N; j++) bus.sel_for_op[j] <= gnt_op[j];
endmodule

// File: tb/tb_switch_alloc_main.sv
// tb_switch_alloc_main: directed self-checking bench for switch_alloc_main
module tb_switch_alloc_main;
   import switch_alloc_main_pkg::*;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int checks = 0;
   int errors = 0;
   switch_alloc_main_if bus ();
   switch_alloc_main dut (.clk(clk), .rstn(rstn), .bus(bus));
   always #5 clk = ~clk;

   task automatic idle();
      bus.req_from_p = '0;
      bus.tail_from_p = '1;
      bus.credit_avail = '1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      bus.req_from_p[0] = 5'b00001;
      tick();
      #2 rstn = 1'b0;
      #1;
      checks++; if (bus.sel_for_op !== '0) begin errors++; $display("FAIL reset_sel got %h exp 0", bus.sel_for_op); end
      checks++; if (bus.grant_to_p !== 5'b00000) begin errors++; $display("FAIL reset_grant got %b exp 00000", bus.grant_to_p); end
      rstn = 1'b1;
      idle();
      bus.req_from_p[2] = 5'b00010;
      #1;
      checks++; if (bus.grant_to_p !== 5'b00100) begin errors++; $display("FAIL first_grant got %b exp 00100", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[1] !== 5'b00100) begin errors++; $display("FAIL first_sel got %b exp 00100", bus.sel_for_op[1]); end
      idle();
      tick();
      checks++; if (bus.sel_for_op[1] !== 5'b00000) begin errors++; $display("FAIL first_sel_clear got %b exp 00000", bus.sel_for_op[1]); end
   endtask

   task automatic test_contention();
      idle();
      bus.req_from_p[0] = 5'b10000;
      bus.req_from_p[3] = 5'b10000;
      #1;
      checks++; if (bus.grant_to_p !== 5'b00001) begin errors++; $display("FAIL cont_grant0 got %b exp 00001", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[4] !== 5'b00001) begin errors++; $display("FAIL cont_sel0 got %b exp 00001", bus.sel_for_op[4]); end
      bus.req_from_p[0] = 5'b00000;
      #1;
      checks++; if (bus.grant_to_p !== 5'b01000) begin errors++; $display("FAIL cont_grant1 got %b exp 01000", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[4] !== 5'b01000) begin errors++; $display("FAIL cont_sel1 got %b exp 01000", bus.sel_for_op[4]); end
      idle();
      tick();
   endtask

   task automatic test_rr_wrap();
      idle();
      bus.req_from_p[3] = 5'b00001;
      #1;
      checks++; if (bus.grant_to_p !== 5'b01000) begin errors++; $display("FAIL wrap_p3 got %b exp 01000", bus.grant_to_p); end
      tick();
      bus.req_from_p[3] = 5'b00000;
      bus.req_from_p[1] = 5'b00001;
      bus.req_from_p[4] = 5'b00001;
      #1;
      checks++; if (bus.grant_to_p !== 5'b10000) begin errors++; $display("FAIL wrap_p4 got %b exp 10000", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[0] !== 5'b10000) begin errors++; $display("FAIL wrap_sel_p4 got %b exp 10000", bus.sel_for_op[0]); end
      #1;
      checks++; if (bus.grant_to_p !== 5'b00010) begin errors++; $display("FAIL wrap_p1 got %b exp 00010", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[0] !== 5'b00010) begin errors++; $display("FAIL wrap_sel_p1 got %b exp 00010", bus.sel_for_op[0]); end
      idle();
   endtask

   task automatic test_lock();
      idle();
      bus.req_from_p[1] = 5'b00001;
      bus.tail_from_p[1] = 1'b0;
      #1;
      checks++; if (bus.grant_to_p !== 5'b00010) begin errors++; $display("FAIL lock_head got %b exp 00010", bus.grant_to_p); end
      tick();
      bus.req_from_p[4] = 5'b00001;
      #1;
      checks++; if (bus.grant_to_p !== 5'b00010) begin errors++; $display("FAIL lock_body0 got %b exp 00010", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[0] !== 5'b00010) begin errors++; $display("FAIL lock_sel_body0 got %b exp 00010", bus.sel_for_op[0]); end
      bus.req_from_p[1] = 5'b00000;
      #1;
      checks++; if (bus.grant_to_p !== 5'b00000) begin errors++; $display("FAIL lock_stall got %b exp 00000", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[0] !== 5'b00000) begin errors++; $display("FAIL lock_sel_stall got %b exp 00000", bus.sel_for_op[0]); end
      bus.req_from_p[1] = 5'b00001;
      #1;
      checks++; if (bus.grant_to_p !== 5'b00010) begin errors++; $display("FAIL lock_body1 got %b exp 00010", bus.grant_to_p); end
      tick();
      bus.tail_from_p[1] = 1'b1;
      #1;
      checks++; if (bus.grant_to_p !== 5'b00010) begin errors++; $display("FAIL lock_tail got %b exp 00010", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[0] !== 5'b00010) begin errors++; $display("FAIL lock_sel_tail got %b exp 00010", bus.sel_for_op[0]); end
      bus.req_from_p[1] = 5'b00000;
      #1;
      checks++; if (bus.grant_to_p !== 5'b10000) begin errors++; $display("FAIL lock_release got %b exp 10000", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[0] !== 5'b10000) begin errors++; $display("FAIL lock_sel_release got %b exp 10000", bus.sel_for_op[0]); end
      idle();
   endtask

   task automatic test_credit();
      idle();
      bus.credit_avail[2] = 1'b0;
      bus.req_from_p[3] = 5'b00100;
      #1;
      checks++; if (bus.grant_to_p !== 5'b00000) begin errors++; $display("FAIL credit_block got %b exp 00000", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[2] !== 5'b00000) begin errors++; $display("FAIL credit_sel_block got %b exp 00000", bus.sel_for_op[2]); end
      bus.credit_avail[2] = 1'b1;
      #1;
      checks++; if (bus.grant_to_p !== 5'b01000) begin errors++; $display("FAIL credit_open got %b exp 01000", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[2] !== 5'b01000) begin errors++; $display("FAIL credit_sel_open got %b exp 01000", bus.sel_for_op[2]); end
      idle();
      tick();
   endtask

   task automatic test_parallel();
      logic [N-1:0][N-1:0] exp_sel;
      idle();
      bus.req_from_p[0] = 5'b01000;
      bus.req_from_p[2] = 5'b01100;
      bus.req_from_p[4] = 5'b00010;
      exp_sel = '0;
      exp_sel[3] = 5'b00001;
      exp_sel[2] = 5'b00100;
      exp_sel[1] = 5'b10000;
      #1;
      checks++; if (bus.grant_to_p !== 5'b10101) begin errors++; $display("FAIL par_grant got %b exp 10101", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op !== exp_sel) begin errors++; $display("FAIL par_sel got %h exp %h", bus.sel_for_op, exp_sel); end
      idle();
      tick();
      checks++; if (bus.sel_for_op !== '0) begin errors++; $display("FAIL par_sel_clear got %h exp 0", bus.sel_for_op); end
   endtask

   task automatic test_reset_lock();
      idle();
      bus.req_from_p[1] = 5'b00001;
      bus.tail_from_p[1] = 1'b0;
      #1;
      checks++; if (bus.grant_to_p !== 5'b00010) begin errors++; $display("FAIL rlock_head got %b exp 00010", bus.grant_to_p); end
      tick();
      bus.req_from_p[1] = 5'b00000;
      #2 rstn = 1'b0;
      #1;
      checks++; if (bus.sel_for_op !== '0) begin errors++; $display("FAIL rlock_sel got %h exp 0", bus.sel_for_op); end
      rstn = 1'b1;
      bus.req_from_p[4] = 5'b00001;
      #1;
      checks++; if (bus.grant_to_p !== 5'b10000) begin errors++; $display("FAIL rlock_p4 got %b exp 10000", bus.grant_to_p); end
      tick();
      checks++; if (bus.sel_for_op[0] !== 5'b10000) begin errors++; $display("FAIL rlock_sel_p4 got %b exp 10000", bus.sel_for_op[0]); end
      idle();
   endtask

   initial begin
      idle();
      tick();
      tick();
      rstn = 1'b1;
      test_reset();
      test_contention();
      test_rr_wrap();
      test_lock();
      test_credit();
      test_parallel();
      test_reset_lock();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
